// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, RD_PORTS registered read ports, optional zero register,
// and a one-entry-per-cycle clear sweep after reset or on request. Optional macro: REGFILE_BYPASS_EN (write-first reads).
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            Write_Reg,
  input  logic [DATA_W-1:0]            Write_Data,
  input  logic                         Read_En,
  input  logic [RD_PORTS*ADDR_W-1:0]   Read_Reg,
  output logic [RD_PORTS*DATA_W-1:0]   ReadData,
  input  logic                         Clear_Req,
  output logic                         Busy,
  output logic                         Clear_Done
);

  localparam int unsigned DEPTH   = 2**ADDR_W;
  localparam bit          ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                       state, state_nx;
  logic [ADDR_W-1:0]            ptr, ptr_nx;
  logic                         busy_nx;
  logic                         done_nx;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_wa;
  logic [DATA_W-1:0]            mem_wd;
  logic [RD_PORTS*DATA_W-1:0]   rd_nx;

  logic [DATA_W-1:0]            mem [DEPTH];

  // Next-state, sweep pointer and array write-port selection
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    busy_nx  = Busy;
    done_nx  = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = Write_Reg;
    mem_wd   = Write_Data;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = ptr;
        mem_wd = '0;
        ptr_nx = ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state_nx = RUN;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      RUN: begin
        if (RegWrite && !(ZERO_EN && (Write_Reg == '0))) begin
          mem_we = 1'b1;
        end
        // Clear request still lets this cycle's write land
        if (Clear_Req) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
          busy_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = CLEAR;
        ptr_nx   = '0;
        busy_nx  = 1'b1;
      end
    endcase
  end

  // Per-port read data selection, loaded into ReadData when Read_En is high
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] word;

    assign ra = Read_Reg[k*ADDR_W +: ADDR_W];

    always_comb begin
      word = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (RegWrite && (ra == Write_Reg)) begin
        word = Write_Data;
      end
`endif
      if (ZERO_EN && (ra == '0)) begin
        word = '0;
      end
      if (state == CLEAR) begin
        word = '0;
      end
    end

    assign rd_nx[k*DATA_W +: DATA_W] = word;
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CLEAR;
      ptr        <= '0;
      Busy       <= 1'b1;
      Clear_Done <= 1'b0;
      ReadData   <= '0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      Busy       <= busy_nx;
      Clear_Done <= done_nx;
      if (Read_En) begin
        ReadData <= rd_nx;
      end
    end
  end

  // Storage array carries no reset; the sweep zeroes it
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed plan steps followed by random traffic, checked against a
// behavioural model (array contents plus a remaining-sweep-cycles counter).
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;
  logic        Read_En;
  logic [9:0]  Read_Reg;
  logic [63:0] ReadData;
  logic        Clear_Req;
  logic        Busy;
  logic        Clear_Done;

  int checks;
  int errors;

  logic [31:0] m_mem [32];
  logic [31:0] m_rd  [2];
  int          sweep_left;
  logic        m_busy;
  logic        m_done;

  wire [31:0] rd0 = ReadData[31:0];
  wire [31:0] rd1 = ReadData[63:32];

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .RD_PORTS(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .Write_Reg(Write_Reg),
    .Write_Data(Write_Data), .Read_En(Read_En), .Read_Reg(Read_Reg),
    .ReadData(ReadData), .Clear_Req(Clear_Req), .Busy(Busy), .Clear_Done(Clear_Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs held across it
  task automatic model_step();
    logic [4:0]  a;
    logic [31:0] v;
    if (!rst_n) begin
      sweep_left = 32;
      m_busy     = 1'b1;
      m_done     = 1'b0;
      m_rd[0]    = '0;
      m_rd[1]    = '0;
    end else if (sweep_left > 0) begin
      m_mem[32 - sweep_left] = '0;
      sweep_left--;
      m_busy = (sweep_left != 0);
      m_done = (sweep_left == 0);
      if (Read_En) begin
        m_rd[0] = '0;
        m_rd[1] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        a = Read_Reg[k*5 +: 5];
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && (a == Write_Reg)) v = Write_Data;
`endif
        if (a == 5'd0) v = '0;
        if (Read_En) m_rd[k] = v;
      end
      if (RegWrite && (Write_Reg != 5'd0)) m_mem[Write_Reg] = Write_Data;
      m_done = 1'b0;
      if (Clear_Req) begin
        sweep_left = 32;
        m_busy     = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("busy", 32'(Busy), 32'(m_busy));
    check("clear_done", 32'(Clear_Done), 32'(m_done));
    check("rd0_model", rd0, m_rd[0]);
    check("rd1_model", rd1, m_rd[1]);
  endtask

  // Counts Busy cycles of a sweep that has just started; optional write attempt mid-sweep
  task automatic count_busy(input string tag, input int wr_at);
    int n;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == wr_at) begin
        RegWrite = 1'b1; Write_Reg = 5'd3; Write_Data = 32'h55;
      end else begin
        RegWrite = 1'b0;
      end
      tick();
      if (Busy) n++;
      else break;
    end
    RegWrite = 1'b0;
    check(tag, 32'(n), 32'd32);
    check("done_pulse", 32'(Clear_Done), 32'd1);
    tick();
    check("done_drop", 32'(Clear_Done), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    sweep_left = 32; m_busy = 1'b1; m_done = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    rst_n = 1'b0; RegWrite = 1'b0; Write_Reg = '0; Write_Data = '0;
    Read_En = 1'b0; Read_Reg = '0; Clear_Req = 1'b0;

    // Reset and initial sweep
    tick(); tick();
    check("rst_busy", 32'(Busy), 32'd1);
    check("rst_rd", rd0, 32'd0);
    rst_n = 1'b1;
    count_busy("rst_sweep_len", -1);
    Read_En = 1'b1; Read_Reg = {5'd31, 5'd1};
    tick();
    check("swept_r1", rd0, 32'd0);
    check("swept_r31", rd1, 32'd0);

    // Basic write then read
    Read_En = 1'b0; RegWrite = 1'b1; Write_Reg = 5'd11; Write_Data = 32'h0000000D;
    tick();
    RegWrite = 1'b0; Read_En = 1'b1; Read_Reg = {5'd10, 5'd11};
    tick();
    check("wr_r11", rd0, 32'h0000000D);
    check("wr_r10", rd1, 32'h00000000);

    // Zero register
    RegWrite = 1'b1; Write_Reg = 5'd0; Write_Data = 32'hFFFFFFFF; Read_En = 1'b0;
    tick();
    RegWrite = 1'b0; Read_En = 1'b1; Read_Reg = {5'd0, 5'd0};
    tick();
    check("zero_p0", rd0, 32'd0);
    check("zero_p1", rd1, 32'd0);

    // Same-cycle collision
    RegWrite = 1'b1; Write_Reg = 5'd5; Write_Data = 32'h11; Read_En = 1'b0;
    tick();
    Write_Data = 32'h22; Read_En = 1'b1; Read_Reg = {5'd5, 5'd5};
    tick();
`ifdef REGFILE_BYPASS_EN
    check("coll_p0", rd0, 32'h22);
    check("coll_p1", rd1, 32'h22);
`else
    check("coll_p0", rd0, 32'h11);
    check("coll_p1", rd1, 32'h11);
`endif
    RegWrite = 1'b0;
    tick();
    check("coll_next", rd0, 32'h22);

    // Fill, then clear with a dropped mid-sweep write
    Read_En = 1'b0;
    for (int i = 1; i < 32; i++) begin
      RegWrite = 1'b1; Write_Reg = 5'(i); Write_Data = 32'(i);
      tick();
    end
    RegWrite = 1'b0; Read_En = 1'b1; Read_Reg = {5'd31, 5'd17};
    tick();
    check("fill_r17", rd0, 32'd17);
    check("fill_r31", rd1, 32'd31);
    Read_En = 1'b0; Clear_Req = 1'b1;
    tick();
    Clear_Req = 1'b0;
    count_busy("clr_sweep_len", 9);
    Read_En = 1'b1;
    for (int i = 0; i < 32; i++) begin
      Read_Reg = {5'(31 - i), 5'(i)};
      tick();
      check("clr_rd_a", rd0, 32'd0);
      check("clr_rd_b", rd1, 32'd0);
    end

    // Reset mid-sweep with non-zero ReadData held
    Read_En = 1'b0; RegWrite = 1'b1; Write_Reg = 5'd7; Write_Data = 32'hABCD;
    tick();
    RegWrite = 1'b0; Read_En = 1'b1; Read_Reg = {5'd7, 5'd7};
    tick();
    check("pre_rst_rd", rd0, 32'hABCD);
    Read_En = 1'b0; Clear_Req = 1'b1;
    tick();
    Clear_Req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_rd0", rd0, 32'd0);
    check("midrst_rd1", rd1, 32'd0);
    check("midrst_busy", 32'(Busy), 32'd1);
    tick();
    rst_n = 1'b1;
    count_busy("midrst_sweep_len", -1);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      Clear_Req  = ($urandom_range(0, 119) == 0);
      RegWrite   = $urandom_range(0, 1) == 1;
      Write_Reg  = 5'($urandom_range(0, 31));
      Write_Data = $urandom;
      Read_En    = ($urandom_range(0, 9) < 7);
      Read_Reg   = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 3) == 0) Read_Reg[4:0] = Write_Reg;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised, clocked general-purpose register file for the single-cycle/multi-cycle datapath: one write port, `RD_PORTS` registered read ports, a hardwired zero register, and a hardware clear sequencer. The array is not reset directly; after reset, or on request, it is swept to zero one entry per cycle. `Busy` flags the sweep to the control unit.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth `DEPTH = 2**ADDR_W`.
- `RD_PORTS`, 2: number of read ports, 1 to 4.
- `ZERO_REG`, 1: when 1, entry 0 reads as zero and ignores writes.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `RegWrite`  in  1  write enable.
- `Write_Reg`  in  ADDR_W  write address.
- `Write_Data`  in  DATA_W  write data.
- `Read_En`  in  1  updates all read outputs when 1.
- `Read_Reg`  in  RD_PORTS*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- `ReadData`  out  RD_PORTS*DATA_W  registered read data; port k uses bits [k*DATA_W +: DATA_W].
- `Clear_Req`  in  1  request a full-array zero sweep.
- `Busy`  out  1  sweep in progress.
- `Clear_Done`  out  1  one-cycle pulse when a sweep completes.

## Operation
- FSM states are `CLEAR` and `RUN`. There is a pointer `ptr` of ADDR_W bits.
- Reset, at an edge with `rst_n`=0, sets:
  - state to `CLEAR` and `ptr` to 0;
  - `Busy` to 1, `Clear_Done` to 0, all `ReadData` to 0.
- `CLEAR` state:
  - Each edge writes 0 to entry `ptr`, then increments `ptr`.
  - At the edge where `ptr`=DEPTH-1, state goes to `RUN`, `Busy` goes to 0, and `Clear_Done` goes to 1 for one cycle.
  - `RegWrite` is ignored and the write is dropped.
  - `Clear_Req` is ignored.
  - If `Read_En`=1, all `ReadData` load 0.
- `RUN` state:
  - `Clear_Req`=1 sets state to `CLEAR`, `ptr` to 0 and `Busy` to 1 on the next edge. A write in that same cycle is still committed.
  - `RegWrite`=1 writes `Write_Data` into entry `Write_Reg` at the edge.
  - With `ZERO_REG`=1, a write to address 0 is discarded.
- Reads in `RUN` with `Read_En`=1: `ReadData[k]` loads the entry at `Read_Reg[k]`. Same-cycle write collisions follow the Configuration rules.
- `ZERO_REG`=1: a read of address 0 always returns 0, bypass included.
- `Read_En`=0: all `ReadData` hold their values.
- Read ports are independent. Identical addresses on several ports return identical data.

## Timing
- Read latency is 1 cycle: an address presented in cycle n appears on `ReadData` after edge n.
- A write at edge n is visible to any read sampled at edge n+1 or later.
- A full sweep takes exactly DEPTH edges after `rst_n` is sampled high, or after the `Clear_Req` edge. `Busy` is 1 for exactly those DEPTH cycles.
- Reasserting reset mid-sweep restarts at `ptr`=0. Reset mid-`RUN` starts a new sweep. Contents written before the reset are undefined until the sweep passes them.
- `Busy` and `Clear_Done` are registered, with no combinational path from the inputs.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-first. In `RUN`, when `RegWrite`=1, `Read_En`=1 and `Read_Reg[k]`==`Write_Reg` at the same edge, `ReadData[k]` loads `Write_Data`. This does not apply to address 0 when `ZERO_REG`=1.
- `REGFILE_BYPASS_EN` undefined: read-first. `ReadData[k]` loads the pre-write contents, and the new value is visible from the next read.

## Test plan
- Reset and sweep: hold `rst_n`=0 for 2 edges, then release.
  - Expect `Busy`=1 for 32 cycles, then `Busy`=0 with `Clear_Done`=1 for exactly one cycle.
  - Reading addresses 1 and 31 then returns 0.
- Basic write/read: write 0x0000000D to reg 11; on the next cycle read ports 0 and 1 at addresses 11 and 10.
  - Expect 0x0000000D and 0x00000000 one cycle later.
- Zero register: write 0xFFFFFFFF to reg 0, then read reg 0 on all ports. Expect 0x00000000.
- Same-cycle collision: reg 5 holds 0x11; write 0x22 to reg 5 while reading reg 5.
  - With `REGFILE_BYPASS_EN`, expect 0x22.
  - Without it, expect 0x11, and 0x22 on the following read.
- Clear during use: fill regs 1–31 with their own index, pulse `Clear_Req`, and drive `RegWrite` of 0x55 to reg 3 mid-sweep.
  - Expect `Busy` for 32 cycles, the mid-sweep write dropped, and all regs reading 0 afterward.
- Reset mid-sweep: assert `rst_n`=0 at sweep cycle 10, then release.
  - Expect `Busy` for a fresh 32 cycles and `ReadData`=0 during reset.
